// File: rtl/linebuf_wrctrl_if.sv
`timescale 1ns/1ps
// linebuf_wrctrl_if: write port from the line-buffer write controller into the two-port line RAM.
// The controller drives the master side and the RAM's write port is the slave.
interface linebuf_wrctrl_if #(
    parameter int PAGE_WIDTH = 1,
    parameter int ADDR_WIDTH = 10,
    parameter int data_width = 32
);
    logic                  wren;
    logic [PAGE_WIDTH-1:0] wrpage;
    logic [ADDR_WIDTH-1:0] wraddr;
    logic [data_width-1:0] wrdata;

    modport master (output wren, wrpage, wraddr, wrdata);
    modport slave  (input  wren, wrpage, wraddr, wrdata);
endinterface

// File: rtl/linebuf_wrctrl.sv
`timescale 1ns/1ps
// linebuf_wrctrl: write-side controller for the line-buffer RAM; stores one video line per page and reports finished lines.
// Optional feature: define LINEBUF_WRCTRL_LINELEN_EN to add the line_len output.
module linebuf_wrctrl #(
    parameter  int num_of_pages = 2,
    parameter  int pagesize     = 1024,
    parameter  int data_width   = 32,
    parameter  int hskip        = 0,
    localparam int PAGE_WIDTH   = (num_of_pages > 1) ? $clog2(num_of_pages) : 1,
    localparam int ADDR_WIDTH   = $clog2(pagesize)
) (
    input  logic                  VCLK,
    input  logic                  RST,
    input  logic                  pix_valid,
    input  logic [data_width-1:0] pix_data,
    input  logic                  hsync,
    input  logic                  vsync,
    linebuf_wrctrl_if.master      wr,
    output logic                  line_done,
    output logic [PAGE_WIDTH-1:0] line_page,
    output logic                  frame_start,
    output logic                  overflow
`ifdef LINEBUF_WRCTRL_LINELEN_EN
    ,
    output logic [ADDR_WIDTH:0]   line_len
`endif
);
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
    localparam int SKIP_WIDTH = (hskip > 0) ? $clog2(hskip + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_LINE,
        S_SKIP,
        S_ACTIVE,
        S_FULL
    } state_t;

    state_t                state;
    state_t                state_next;

    logic                  hs_q;
    logic                  vs_q;
    logic [PAGE_WIDTH-1:0] page;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [SKIP_WIDTH-1:0] skip_cnt;

    logic                  hs_rise;
    logic                  hs_fall;
    logic                  vs_rise;
    logic                  vs_fall;
    logic                  vs_edge;
    logic                  pix_ok;
    logic                  skip_last;
    logic                  addr_last;
    logic                  page_last;
    logic [LEN_WIDTH-1:0]  written_cnt;

    logic                  do_skip;
    logic                  do_write;
    logic                  do_drop;
    logic                  line_start;
    logic                  line_end;
    logic                  commit;

    assign hs_rise   = hsync & ~hs_q;
    assign hs_fall   = ~hsync & hs_q;
    assign vs_rise   = vsync & ~vs_q;
    assign vs_fall   = ~vsync & vs_q;
    assign vs_edge   = vs_rise | vs_fall;
    // A pixel arriving together with any sync edge is dropped.
    assign pix_ok    = pix_valid & ~(vs_edge | hs_rise | hs_fall);

    assign skip_last = (skip_cnt == SKIP_WIDTH'(hskip - 1));
    assign addr_last = (wr_addr == ADDR_WIDTH'(pagesize - 1));
    assign page_last = (page == PAGE_WIDTH'(num_of_pages - 1));
    // In FULL the address counter parks on the last slot, so the length is the page size.
    assign written_cnt = (state == S_FULL) ? LEN_WIDTH'(pagesize) : {1'b0, wr_addr};

    always_ff @(posedge VCLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (vs_rise)                    state_next = S_IDLE;
        else if (vs_fall)               state_next = S_WAIT_LINE;
        else if (line_end)              state_next = S_WAIT_LINE;
        else if (line_start)            state_next = (hskip == 0) ? S_ACTIVE : S_SKIP;
        else if (do_skip && skip_last)  state_next = S_ACTIVE;
        else if (do_write && addr_last) state_next = S_FULL;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        do_skip    = 1'b0;
        do_write   = 1'b0;
        do_drop    = 1'b0;
        line_start = 1'b0;
        line_end   = 1'b0;
        if (!vs_edge) begin
            case (state)
                S_WAIT_LINE: line_start = hs_fall;
                S_SKIP: begin
                    line_end = hs_rise;
                    do_skip  = pix_ok;
                end
                S_ACTIVE: begin
                    line_end = hs_rise;
                    do_write = pix_ok;
                end
                S_FULL: begin
                    line_end = hs_rise;
                    do_drop  = pix_ok;
                end
                default: ;
            endcase
        end
        commit = line_end & (written_cnt != '0);
    end

    // NOTE: non-blocking assignments so every register here samples the pre-edge values of the others.
    always_ff @(posedge VCLK) begin
        if (RST) begin
            hs_q        <= 1'b0;
            vs_q        <= 1'b0;
            page        <= '0;
            wr_addr     <= '0;
            skip_cnt    <= '0;
            wr.wren     <= 1'b0;
            wr.wraddr   <= '0;
            wr.wrdata   <= '0;
            line_done   <= 1'b0;
            line_page   <= '0;
            frame_start <= 1'b0;
            overflow    <= 1'b0;
`ifdef LINEBUF_WRCTRL_LINELEN_EN
            line_len    <= '0;
`endif
        end else begin
            hs_q        <= hsync;
            vs_q        <= vsync;
            wr.wren     <= do_write;
            line_done   <= commit;
            frame_start <= vs_fall;

            if (do_write) begin
                wr.wraddr <= wr_addr;
                wr.wrdata <= pix_data;
            end

            if (vs_edge || line_start || line_end) wr_addr <= '0;
            else if (do_write && !addr_last)       wr_addr <= wr_addr + 1'b1;

            if (line_start)                  skip_cnt <= '0;
            else if (do_skip && !skip_last)  skip_cnt <= skip_cnt + 1'b1;

            if (vs_fall)     page <= '0;
            else if (commit) page <= page_last ? '0 : page + 1'b1;

            if (commit) begin
                line_page <= page;
`ifdef LINEBUF_WRCTRL_LINELEN_EN
                line_len  <= written_cnt;
`endif
            end

            if (line_start)   overflow <= 1'b0;
            else if (do_drop) overflow <= 1'b1;
        end
    end

    assign wr.wrpage = page;

endmodule
